// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: receive side of the multiplexed 4-digit 7-segment bus.
// Filters and decodes each digit, reassembles frames and converts them to binary.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        show_error,
    output logic        decode_err,
    output logic        stale
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STB_SAT  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_HOLD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_HIT  = TW'(TIMEOUT_CYCLES - 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [3:0] C_E     = 4'd10;
    localparam logic [3:0] C_R     = 4'd11;
    localparam logic [3:0] C_BLANK = 4'd12;
    localparam logic [3:0] C_INV   = 4'd15;

    function automatic logic [3:0] seg_decode(input logic [6:0] p);
        case (p)
            7'b1000000: seg_decode = 4'd0;
            7'b1111001: seg_decode = 4'd1;
            7'b0100100: seg_decode = 4'd2;
            7'b0110000: seg_decode = 4'd3;
            7'b0011001: seg_decode = 4'd4;
            7'b0010010: seg_decode = 4'd5;
            7'b0000010: seg_decode = 4'd6;
            7'b1111000: seg_decode = 4'd7;
            7'b0000000: seg_decode = 4'd8;
            7'b0010000: seg_decode = 4'd9;
            7'b0000110: seg_decode = C_E;
            7'b0101111: seg_decode = C_R;
            7'b1111111: seg_decode = C_BLANK;
            default:    seg_decode = C_INV;
        endcase
    endfunction

    logic [6:0]        seg_s1, seg_s2;
    logic [3:0]        an_s1, an_s2;
    logic [10:0]       samp_q;
    logic [CW-1:0]     stab_cnt;
    logic              same, strobe, one_low, accept;
    logic [1:0]        dig_idx;
    logic [3:0]        dig_code;
    logic [3:0][3:0]   slots, slots_nxt, shadow;
    logic [3:0]        seen, seen_nxt;
    logic              frame_done, shadow_new;
    logic [TW-1:0]     tcnt;
    logic              timeout_hit;
    logic [0:0]        state;
    logic [1:0]        conv_idx;
    logic [13:0]       acc, horner;
    logic              all_num, is_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
            an_s1  <= an;
            an_s2  <= an_s1;
        end
    end

    // One strobe per stable run: the counter saturates past the strobe point.
    assign same   = ({an_s2, seg_s2} == samp_q);
    assign strobe = same && (stab_cnt == STB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q   <= '1;
            stab_cnt <= STB_SAT;
        end else begin
            samp_q <= {an_s2, seg_s2};
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != STB_SAT)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    always_comb begin
        one_low = 1'b1;
        dig_idx = 2'd0;
        case (an_s2)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign dig_code = seg_decode(seg_s2);
    assign accept   = strobe && one_low;

    always_comb begin
        slots_nxt = slots;
        seen_nxt  = seen;
        if (accept) begin
            slots_nxt[dig_idx] = dig_code;
            seen_nxt[dig_idx]  = 1'b1;
        end
    end

    assign frame_done  = accept && (seen_nxt == 4'hF);
    assign timeout_hit = !accept && (tcnt == TMO_HIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots      <= '0;
            seen       <= '0;
            shadow     <= '0;
            shadow_new <= 1'b0;
            tcnt       <= '0;
        end else begin
            slots      <= slots_nxt;
            shadow_new <= frame_done;
            if (frame_done)
                shadow <= slots_nxt;
            if (timeout_hit || frame_done)
                seen <= '0;
            else
                seen <= seen_nxt;
            if (accept)
                tcnt <= '0;
            else if (tcnt != TMO_HOLD)
                tcnt <= tcnt + 1'b1;
        end
    end

    always_comb begin
        all_num = 1'b1;
        for (int i = 0; i < 4; i++)
            if (shadow[i] > 4'd9)
                all_num = 1'b0;
    end

    assign is_err = (shadow == {C_E, C_R, C_R, C_BLANK});
    assign horner = (acc << 3) + (acc << 1) + {10'd0, shadow[conv_idx]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            conv_idx    <= 2'd0;
            acc         <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            show_error  <= 1'b0;
            decode_err  <= 1'b0;
            stale       <= 1'b1;
        end else begin
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
            if (timeout_hit)
                stale <= 1'b1;
            case (state)
                IDLE: begin
                    if (shadow_new) begin
                        if (is_err) begin
                            show_error  <= 1'b1;
                            stale       <= 1'b0;
                            frame_valid <= 1'b1;
                        end else if (all_num) begin
                            state    <= CONV;
                            conv_idx <= 2'd3;
                            acc      <= '0;
                        end else begin
                            decode_err <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    acc      <= horner;
                    conv_idx <= conv_idx - 1'b1;
                    if (conv_idx == 2'd0) begin
                        value       <= horner;
                        show_error  <= 1'b0;
                        stale       <= 1'b0;
                        frame_valid <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed and randomized frames against a
// frame-level reference model of the 7-segment receiver.
module tb_seg7_scan_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [13:0] value;
    logic        frame_valid;
    logic        show_error;
    logic        decode_err;
    logic        stale;

    seg7_scan_capture #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg        (seg),
        .an         (an),
        .value      (value),
        .frame_valid(frame_valid),
        .show_error (show_error),
        .decode_err (decode_err),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int de_cnt = 0;
    int last_fv_cyc = 0;
    int last_evt_cyc = 0;

    logic [6:0] pat [13];

    int         m_slot [4];
    logic [3:0] m_seen;
    int         m_value;
    logic       m_err;
    logic       m_stale;
    int         exp_fv;
    int         exp_de;
    int         m_done_drv;
    int         l_num;
    int         l_err;

    localparam logic [7:0] ORD_SEQ = 8'b11_10_01_00;
    localparam logic [7:0] ORD_SCR = 8'b01_11_00_10;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!reset) begin
            chk("fv_de_exclusive", 32'(frame_valid & decode_err), 0);
            if (frame_valid || decode_err) begin
                if (last_evt_cyc != 0)
                    chk("no_frame_during_conv",
                        32'((cyc - last_evt_cyc) >= 5), 1);
                last_evt_cyc = cyc;
            end
            if (frame_valid) begin
                fv_cnt++;
                last_fv_cyc = cyc;
            end
            if (decode_err)
                de_cnt++;
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int c = 0; c < 13; c++)
            if (pat[c] == s)
                return c;
        return 15;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++)
            m_slot[i] = 0;
        m_seen  = 4'h0;
        m_value = 0;
        m_err   = 1'b0;
        m_stale = 1'b1;
    endtask

    // A frame is whatever the four slots hold when the last missing digit lands.
    task automatic m_capture(input logic [3:0] a, input logic [6:0] s,
                             input int drv);
        int  k;
        logic nums;
        k = -1;
        for (int i = 0; i < 4; i++)
            if (a == ~(4'b0001 << i))
                k = i;
        if (k < 0)
            return;
        m_slot[k] = lookup(s);
        m_seen[k] = 1'b1;
        if (m_seen != 4'hF)
            return;
        m_seen     = 4'h0;
        m_done_drv = drv;
        nums = 1'b1;
        for (int i = 0; i < 4; i++)
            if (m_slot[i] > 9)
                nums = 1'b0;
        if (m_slot[3] == 10 && m_slot[2] == 11 && m_slot[1] == 11 &&
            m_slot[0] == 12) begin
            m_err   = 1'b1;
            m_stale = 1'b0;
            exp_fv++;
        end else if (nums) begin
            m_value = m_slot[3] * 1000 + m_slot[2] * 100 +
                      m_slot[1] * 10 + m_slot[0];
            m_err   = 1'b0;
            m_stale = 1'b0;
            exp_fv++;
        end else begin
            exp_de++;
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s,
                         input int n);
        int drv;
        an  = a;
        seg = s;
        drv = cyc;
        repeat (n) tick();
        if (n >= STABLE + 3)
            m_capture(a, s, drv);
    endtask

    function automatic logic [3:0][6:0] to_pats(input int v);
        logic [3:0][6:0] p;
        p[0] = pat[v % 10];
        p[1] = pat[(v / 10) % 10];
        p[2] = pat[(v / 100) % 10];
        p[3] = pat[(v / 1000) % 10];
        return p;
    endfunction

    task automatic scan(input logic [3:0][6:0] p, input logic [7:0] ord,
                        input int n);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = int'(ord[2*i +: 2]);
            dwell(~(4'b0001 << k), p[k], n);
        end
    endtask

    task automatic settle();
        dwell(4'b1111, 7'h7F, 24);
    endtask

    task automatic check_state(input string t);
        chk({t, "_value"}, 32'(value), m_value);
        chk({t, "_show_error"}, 32'(show_error), 32'(m_err));
        chk({t, "_stale"}, 32'(stale), 32'(m_stale));
        chk({t, "_fv_count"}, fv_cnt, exp_fv);
        chk({t, "_de_count"}, de_cnt, exp_de);
    endtask

    initial begin
        logic [3:0][6:0] p;
        logic [7:0]      ord;
        int              o [4];
        int              j, tmp, v, n;
        logic [3:0]      bad_an [4];

        pat[0]  = 7'b1000000;
        pat[1]  = 7'b1111001;
        pat[2]  = 7'b0100100;
        pat[3]  = 7'b0110000;
        pat[4]  = 7'b0011001;
        pat[5]  = 7'b0010010;
        pat[6]  = 7'b0000010;
        pat[7]  = 7'b1111000;
        pat[8]  = 7'b0000000;
        pat[9]  = 7'b0010000;
        pat[10] = 7'b0000110;
        pat[11] = 7'b0101111;
        pat[12] = 7'b1111111;
        bad_an[0] = 4'b1100;
        bad_an[1] = 4'b0000;
        bad_an[2] = 4'b1010;
        bad_an[3] = 4'b1111;

        m_reset();
        exp_fv     = 0;
        exp_de     = 0;
        m_done_drv = 0;
        reset = 1'b1;
        an    = 4'hF;
        seg   = 7'h7F;
        repeat (3) tick();
        chk("rst_value", 32'(value), 0);
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_show_error", 32'(show_error), 0);
        chk("rst_decode_err", 32'(decode_err), 0);
        chk("rst_stale", 32'(stale), 1);
        reset = 1'b0;
        tick();

        // 1234 scanned for three rotations
        repeat (3) scan(to_pats(1234), ORD_SEQ, 64);
        settle();
        check_state("t1");
        l_num = last_fv_cyc - m_done_drv;
        chk("t1_latency_window",
            32'(l_num >= STABLE + 5 && l_num <= STABLE + 12), 1);

        // Err frame: blank,r,r,E on digits 0..3
        p[0] = pat[12];
        p[1] = pat[11];
        p[2] = pat[11];
        p[3] = pat[10];
        scan(p, ORD_SEQ, 64);
        settle();
        check_state("t2");
        l_err = last_fv_cyc - m_done_drv;
        chk("t2_conv_extra_cycles", l_num - l_err, 4);

        // 2-cycle glitch showing 8 inside the tens dwell
        dwell(4'b1110, pat[4], 64);
        dwell(4'b1101, pat[3], 30);
        dwell(4'b1101, pat[8], 2);
        dwell(4'b1101, pat[3], 32);
        dwell(4'b1011, pat[2], 64);
        dwell(4'b0111, pat[1], 64);
        settle();
        check_state("t3");

        // unrecognised pattern on digit 2
        p = to_pats(1234);
        p[2] = 7'b1010101;
        scan(p, ORD_SEQ, 64);
        settle();
        check_state("t4");

        scan(to_pats(9999), ORD_SEQ, 64);
        settle();
        check_state("t5_9999");
        scan(to_pats(0), ORD_SEQ, 64);
        settle();
        check_state("t5_0000");
        scan(to_pats(4701), ORD_SCR, 64);
        settle();
        check_state("t5_scrambled");

        // randomized frames, orders, dwells, junk anodes and corrupt digits
        for (int it = 0; it < 10; it++) begin
            v = int'($urandom_range(0, 9999));
            p = to_pats(v);
            if ($urandom_range(0, 3) == 0)
                p[$urandom_range(0, 3)] = 7'($urandom);
            for (int i = 0; i < 4; i++)
                o[i] = i;
            for (int i = 3; i > 0; i--) begin
                j    = int'($urandom_range(0, i));
                tmp  = o[i];
                o[i] = o[j];
                o[j] = tmp;
            end
            ord = {2'(o[3]), 2'(o[2]), 2'(o[1]), 2'(o[0])};
            n = int'($urandom_range(20, 80));
            if ($urandom_range(0, 1) == 0)
                dwell(bad_an[$urandom_range(0, 3)], 7'($urandom), 30);
            scan(p, ord, n);
            settle();
            check_state("rand");
        end

        // timeout drops a partial frame
        scan(to_pats(5678), ORD_SEQ, 64);
        settle();
        check_state("t6_base");
        p = to_pats(5678);
        dwell(4'b1110, p[0], 64);
        dwell(4'b1101, p[1], 64);
        dwell(4'b1111, 7'h7F, 200);
        check_state("t6_before_timeout");
        dwell(4'b1111, 7'h7F, TMO);
        m_seen  = 4'h0;
        m_stale = 1'b1;
        check_state("t6_after_timeout");
        dwell(4'b1011, p[2], 64);
        dwell(4'b0111, p[3], 64);
        settle();
        check_state("t6_seen_cleared");
        dwell(4'b1110, p[0], 64);
        dwell(4'b1101, p[1], 64);
        settle();
        check_state("t6_recovered");

        // reset while the conversion of 4321 is in flight
        p = to_pats(4321);
        dwell(4'b1110, p[0], 64);
        dwell(4'b1101, p[1], 64);
        dwell(4'b1011, p[2], 64);
        an  = 4'b0111;
        seg = p[3];
        repeat (9) tick();
        chk("t7_pre_value", 32'(value), m_value);
        chk("t7_pre_fv_count", fv_cnt, exp_fv);
        reset = 1'b1;
        #1;
        chk("t7_rst_value", 32'(value), 0);
        chk("t7_rst_frame_valid", 32'(frame_valid), 0);
        chk("t7_rst_show_error", 32'(show_error), 0);
        chk("t7_rst_decode_err", 32'(decode_err), 0);
        chk("t7_rst_stale", 32'(stale), 1);
        an  = 4'hF;
        seg = 7'h7F;
        repeat (4) tick();
        reset = 1'b0;
        m_reset();
        repeat (40) tick();
        check_state("t7_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
